tlu_record_reader: RTL and testbench
====================================

# tlu_record_reader

Consumer for the TLU master trigger-record FIFO port. It pops the 16-bit show-ahead word stream on BUS_CLK and reassembles each 8-word record into trigger ID, 64-bit timestamp and four leading-edge bytes. Each record is presented on a valid/ready output with continuity and monotonicity checks. It sits between the TLU master core and on-chip consumers (event builder, DUT data merger) that need whole trigger records rather than raw words.

## Interface
- No parameters.
- BUS_CLK  in  1  clock; all logic on rising edge.
- RST  in  1  reset, synchronous, active-high; must be the same reset that clears the producer's word counter.
- ENABLE  in  1  permits starting a new record; sampled only at word 0.
- CLEAR_CNT  in  1  single-cycle pulse; clears counters and check history.
- FIFO_EMPTY  in  1  producer empty flag.
- FIFO_DATA  in  16  current word, valid whenever FIFO_EMPTY=0 (show-ahead).
- FIFO_READ  out  1  pops the current word.
- REC_VALID  out  1  record available.
- REC_READY  in  1  consumer accepts record.
- REC_TRIG_ID  out  32  trigger ID.
- REC_TIME_STAMP  out  64  40 MHz timestamp.
- REC_LE  out  32  {LE3, LE2, LE1, LE0}, each byte a relative leading edge.
- REC_CNT  out  32  records delivered, wraps.
- ID_ERR_CNT  out  16  trigger-ID discontinuities, saturates at 16'hFFFF.
- TS_ERR_CNT  out  16  non-increasing timestamps, saturates at 16'hFFFF.

## Operation
- Word order (index 0..7):
  - 0: {LE1, LE0}
  - 1: {LE3, LE2}
  - 2–5: TIME_STAMP[15:0], [31:16], [47:32], [63:48]
  - 6: TRIG_ID[15:0]
  - 7: TRIG_ID[31:16]
- FSM states:
  - COLLECT: 3-bit word_cnt.
    - FIFO_READ = !FIFO_EMPTY && (word_cnt != 0 || ENABLE). This is combinational and forced to 0 under RST.
    - On each FIFO_READ cycle, FIFO_DATA is latched into the slice selected by word_cnt, and word_cnt increments.
    - When word 7 is read, go to HOLD.
  - HOLD: REC_VALID=1, no reads. On REC_VALID && REC_READY, return to COLLECT with word_cnt=0.
- ENABLE deassertion mid-record does not abort; the record completes. FIFO_EMPTY mid-record stalls reads without loss.
- REC_* data outputs are assembly registers. They are stable throughout HOLD and are changed in COLLECT only by the latch writes for the next record.
- Checks are evaluated at the transition into HOLD, against the previously delivered record:
  - ID error if has_prev && TRIG_ID != prev_id + 1 (mod 2^32).
  - TS error if has_prev && TIME_STAMP <= prev_ts (unsigned).
  - Then prev_id/prev_ts are updated, has_prev is set, and REC_CNT increments.
- The first record after RST or CLEAR_CNT is never flagged.
- CLEAR_CNT zeroes REC_CNT, ID_ERR_CNT, TS_ERR_CNT and has_prev. It does not affect the FSM or record data. If CLEAR_CNT coincides with a check update, the clear wins.

## Timing
- Reset values: FIFO_READ=0, REC_VALID=0, REC_TRIG_ID=0, REC_TIME_STAMP=0, REC_LE=0, all counters 0, state COLLECT, word_cnt=0, has_prev=0.
- With the FIFO continuously non-empty, words 0..7 are read in 8 consecutive cycles N..N+7.
- REC_VALID rises at N+8. Counters and error counts are updated in the same edge.
- Handshake completes at edge M. Next FIFO_READ is possible at cycle M+1 (after that edge).
- Minimum record period: 9 cycles.
- REC_READY held high continuously gives a 9-cycle period. REC_READY low holds the record indefinitely; the producer buffers.
- RST mid-record discards the partial record. Alignment is preserved only because the producer's word counter resets on the same RST.

## Structure
- Shared package tlu_pkg:
  - localparam TLU_WORDS_PER_REC = 8
  - word-index constants (TLU_W_LE01=0, TLU_W_LE23=1, TLU_W_TS0=2, TLU_W_ID0=6)
  - TLU_REC_BITS = 128
- One sub-module: tlu_rec_checker. It holds prev_id/prev_ts/has_prev and the two saturating counters, and is driven by a single rec_done strobe. The FSM and word assembly stay in the top module.

## Test plan
- Single record with LE bytes 11,22,33,44, TS=64'h0000_0001_0000_00A5, ID=1 → REC_VALID at read+8, with REC_LE=32'h44332211, REC_TIME_STAMP and REC_TRIG_ID matching, REC_CNT=1, both error counts 0.
- IDs 1,2,4 with increasing TS, REC_READY=1 → ID_ERR_CNT=1, TS_ERR_CNT=0, REC_CNT=3, records 9 cycles apart.
- TS 100 then 100 → TS_ERR_CNT=1.
- Wrap: ID 32'hFFFFFFFF then 0 → no ID error.
- REC_READY=0 for 50 cycles after REC_VALID → no FIFO_READ and stable outputs throughout. REC_READY=1 → next FIFO_READ one cycle after the handshake.
- FIFO_EMPTY toggled every other cycle mid-record; ENABLE dropped at word 3 → record completes correctly and no new record starts.
- RST at word 4 → all outputs return to reset values, and the next record assembles correctly from word 0.

Source files
------------

// File: rtl/tlu_pkg.sv
// Shared constants and record layout for the TLU trigger-record path.
// A record is 8 x 16-bit words; word i lands at bits [16*i +: 16] of the record.
package tlu_pkg;

    localparam int TLU_WORDS_PER_REC = 8;
    localparam int TLU_WORD_BITS     = 16;
    localparam int TLU_REC_BITS      = 128;

    localparam logic [2:0] TLU_W_LE01 = 3'd0;
    localparam logic [2:0] TLU_W_LE23 = 3'd1;
    localparam logic [2:0] TLU_W_TS0  = 3'd2;
    localparam logic [2:0] TLU_W_ID0  = 3'd6;
    localparam logic [2:0] TLU_W_LAST = 3'd7;

    // Field order matches the word order, so a flat 128-bit assembly casts directly.
    typedef struct packed {
        logic [31:0] trig_id;
        logic [63:0] time_stamp;
        logic [31:0] le;
    } tlu_rec_t;

endpackage

// File: rtl/tlu_rec_checker.sv
// Continuity (trigger ID) and monotonicity (timestamp) checks across delivered records.
// Compares each completed record against the previous one and keeps saturating error counts.
module tlu_rec_checker
    import tlu_pkg::*;
(
    input  logic        BUS_CLK,
    input  logic        RST,
    input  logic        clear_cnt,
    input  logic        rec_done,
    input  logic [31:0] trig_id,
    input  logic [63:0] time_stamp,
    output logic [15:0] id_err_cnt,
    output logic [15:0] ts_err_cnt
);

    logic [31:0] prev_id_reg;
    logic [63:0] prev_ts_reg;
    logic        has_prev_reg;
    logic [15:0] id_err_cnt_reg;
    logic [15:0] ts_err_cnt_reg;
    logic        id_err;
    logic        ts_err;

    assign id_err = has_prev_reg && (trig_id != prev_id_reg + 32'd1);
    assign ts_err = has_prev_reg && (time_stamp <= prev_ts_reg);

    always_ff @(posedge BUS_CLK) begin
        if (RST) begin
            prev_id_reg    <= '0;
            prev_ts_reg    <= '0;
            has_prev_reg   <= 1'b0;
            id_err_cnt_reg <= '0;
            ts_err_cnt_reg <= '0;
        end else if (clear_cnt) begin
            // Clear beats a coincident record completion; history restarts empty.
            has_prev_reg   <= 1'b0;
            id_err_cnt_reg <= '0;
            ts_err_cnt_reg <= '0;
        end else if (rec_done) begin
            prev_id_reg  <= trig_id;
            prev_ts_reg  <= time_stamp;
            has_prev_reg <= 1'b1;
            if (id_err && id_err_cnt_reg != 16'hFFFF)
                id_err_cnt_reg <= id_err_cnt_reg + 16'd1;
            if (ts_err && ts_err_cnt_reg != 16'hFFFF)
                ts_err_cnt_reg <= ts_err_cnt_reg + 16'd1;
        end
    end

    assign id_err_cnt = id_err_cnt_reg;
    assign ts_err_cnt = ts_err_cnt_reg;

endmodule

// File: rtl/tlu_record_reader.sv
// Pops the TLU show-ahead word FIFO, assembles 8-word trigger records and
// presents each one on a valid/ready port with continuity/monotonicity counters.
module tlu_record_reader
    import tlu_pkg::*;
(
    input  logic        BUS_CLK,
    input  logic        RST,
    input  logic        ENABLE,
    input  logic        CLEAR_CNT,
    input  logic        FIFO_EMPTY,
    input  logic [15:0] FIFO_DATA,
    output logic        FIFO_READ,
    output logic        REC_VALID,
    input  logic        REC_READY,
    output logic [31:0] REC_TRIG_ID,
    output logic [63:0] REC_TIME_STAMP,
    output logic [31:0] REC_LE,
    output logic [31:0] REC_CNT,
    output logic [15:0] ID_ERR_CNT,
    output logic [15:0] TS_ERR_CNT
);

    localparam logic [0:0] ST_COLLECT = 1'b0;
    localparam logic [0:0] ST_HOLD    = 1'b1;

    logic [0:0]              state_reg;
    logic [2:0]              word_cnt_reg;
    logic [TLU_REC_BITS-1:0] rec_reg;
    logic [TLU_REC_BITS-1:0] rec_next;
    logic [31:0]             rec_cnt_reg;
    logic                    fifo_read;
    logic                    rec_done;
    tlu_rec_t                rec_view;
    tlu_rec_t                rec_next_view;

    // ENABLE only gates the start of a record; once word 0 is taken the record runs to the end.
    assign fifo_read = !RST && (state_reg == ST_COLLECT) && !FIFO_EMPTY
                       && ((word_cnt_reg != TLU_W_LE01) || ENABLE);
    assign rec_done  = fifo_read && (word_cnt_reg == TLU_W_LAST);

    genvar gi;
    generate
        for (gi = 0; gi < TLU_WORDS_PER_REC; gi++) begin : g_word
            assign rec_next[gi*TLU_WORD_BITS +: TLU_WORD_BITS] =
                (fifo_read && word_cnt_reg == 3'(gi)) ? FIFO_DATA
                                                      : rec_reg[gi*TLU_WORD_BITS +: TLU_WORD_BITS];
        end
    endgenerate

    always_ff @(posedge BUS_CLK) begin
        if (RST) begin
            state_reg    <= ST_COLLECT;
            word_cnt_reg <= '0;
            rec_reg      <= '0;
        end else begin
            rec_reg <= rec_next;
            case (state_reg)
                ST_COLLECT: begin
                    if (fifo_read) begin
                        word_cnt_reg <= word_cnt_reg + 3'd1;
                        if (rec_done)
                            state_reg <= ST_HOLD;
                    end
                end
                default: begin
                    if (REC_READY)
                        state_reg <= ST_COLLECT;
                end
            endcase
        end
    end

    always_ff @(posedge BUS_CLK) begin
        if (RST || CLEAR_CNT)
            rec_cnt_reg <= '0;
        else if (rec_done)
            rec_cnt_reg <= rec_cnt_reg + 32'd1;
    end

    // The checker sees the record including the word being latched this cycle.
    assign rec_next_view = rec_next;

    tlu_rec_checker u_checker (
        .BUS_CLK    (BUS_CLK),
        .RST        (RST),
        .clear_cnt  (CLEAR_CNT),
        .rec_done   (rec_done),
        .trig_id    (rec_next_view.trig_id),
        .time_stamp (rec_next_view.time_stamp),
        .id_err_cnt (ID_ERR_CNT),
        .ts_err_cnt (TS_ERR_CNT)
    );

    assign rec_view       = rec_reg;
    assign FIFO_READ      = fifo_read;
    assign REC_VALID      = (state_reg == ST_HOLD);
    assign REC_TRIG_ID    = rec_view.trig_id;
    assign REC_TIME_STAMP = rec_view.time_stamp;
    assign REC_LE         = rec_view.le;
    assign REC_CNT        = rec_cnt_reg;

endmodule

// File: tb/tb_tlu_record_reader.sv
// Scoreboard bench for tlu_record_reader: a show-ahead FIFO model feeds records,
// expected records are queued at push time and checked by a negedge monitor.
module tb_tlu_record_reader;

    logic        BUS_CLK    = 1'b0;
    logic        RST        = 1'b1;
    logic        ENABLE     = 1'b0;
    logic        CLEAR_CNT  = 1'b0;
    logic        FIFO_EMPTY = 1'b1;
    logic [15:0] FIFO_DATA  = 16'h0;
    logic        REC_READY  = 1'b0;
    logic        FIFO_READ;
    logic        REC_VALID;
    logic [31:0] REC_TRIG_ID;
    logic [63:0] REC_TIME_STAMP;
    logic [31:0] REC_LE;
    logic [31:0] REC_CNT;
    logic [15:0] ID_ERR_CNT;
    logic [15:0] TS_ERR_CNT;

    typedef struct {
        logic [31:0] id;
        logic [63:0] ts;
        logic [31:0] le;
        int          cnt;
        int          id_err;
        int          ts_err;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] fifo_q[$];
    int          rise_q[$];
    int          rd_cyc_q[$];
    exp_t        mon_e;
    int          checks   = 0;
    int          errors   = 0;
    int          cyc      = 0;
    int          rd_total = 0;
    bit          rd_pending = 1'b0;
    bit          gap      = 1'b0;
    bit          valid_d  = 1'b0;

    tlu_record_reader dut (
        .BUS_CLK        (BUS_CLK),
        .RST            (RST),
        .ENABLE         (ENABLE),
        .CLEAR_CNT      (CLEAR_CNT),
        .FIFO_EMPTY     (FIFO_EMPTY),
        .FIFO_DATA      (FIFO_DATA),
        .FIFO_READ      (FIFO_READ),
        .REC_VALID      (REC_VALID),
        .REC_READY      (REC_READY),
        .REC_TRIG_ID    (REC_TRIG_ID),
        .REC_TIME_STAMP (REC_TIME_STAMP),
        .REC_LE         (REC_LE),
        .REC_CNT        (REC_CNT),
        .ID_ERR_CNT     (ID_ERR_CNT),
        .TS_ERR_CNT     (TS_ERR_CNT)
    );

    always #5 BUS_CLK = ~BUS_CLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic update_fifo();
        FIFO_EMPTY = (fifo_q.size() == 0) || gap;
        FIFO_DATA  = (fifo_q.size() == 0) ? 16'h0 : fifo_q[0];
    endtask

    task automatic push_rec(input logic [31:0] id, input logic [63:0] ts, input logic [31:0] le,
                            input int cnt, input int ie, input int te, input bit want);
        exp_t e;
        fifo_q.push_back(le[15:0]);
        fifo_q.push_back(le[31:16]);
        fifo_q.push_back(ts[15:0]);
        fifo_q.push_back(ts[31:16]);
        fifo_q.push_back(ts[47:32]);
        fifo_q.push_back(ts[63:48]);
        fifo_q.push_back(id[15:0]);
        fifo_q.push_back(id[31:16]);
        if (want) begin
            e.id = id; e.ts = ts; e.le = le;
            e.cnt = cnt; e.id_err = ie; e.ts_err = te;
            exp_q.push_back(e);
        end
        update_fifo();
    endtask

    task automatic tick();
        @(posedge BUS_CLK);
        #1;
    endtask

    task automatic wait_exp(input int remain, input string name);
        int n = 0;
        while (exp_q.size() > remain && n < 300) begin
            tick();
            n++;
        end
        chk(name, exp_q.size(), remain);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_fifo_read"}, FIFO_READ, 0);
        chk({tag, "_valid"},     REC_VALID, 0);
        chk({tag, "_trig_id"},   REC_TRIG_ID, 0);
        chk({tag, "_ts"},        REC_TIME_STAMP, 0);
        chk({tag, "_le"},        REC_LE, 0);
        chk({tag, "_rec_cnt"},   REC_CNT, 0);
        chk({tag, "_id_err"},    ID_ERR_CNT, 0);
        chk({tag, "_ts_err"},    TS_ERR_CNT, 0);
    endtask

    task automatic pulse_clear();
        CLEAR_CNT = 1'b1;
        tick();
        CLEAR_CNT = 1'b0;
        @(negedge BUS_CLK);
        chk("clear_rec_cnt", REC_CNT, 0);
        chk("clear_id_err",  ID_ERR_CNT, 0);
        chk("clear_ts_err",  TS_ERR_CNT, 0);
        tick();
    endtask

    // FIFO model: pop after the edge at which the DUT consumed the word
    always @(posedge BUS_CLK) begin
        cyc++;
        #1;
        if (rd_pending && fifo_q.size() > 0) begin
            void'(fifo_q.pop_front());
            update_fifo();
        end
    end

    // Monitor: one scoreboard comparison set per presented record
    always @(negedge BUS_CLK) begin
        if (FIFO_READ) begin
            rd_total++;
            rd_cyc_q.push_back(cyc);
        end
        rd_pending = FIFO_READ;
        if (REC_VALID && !valid_d) begin
            rise_q.push_back(cyc);
            $display("record @%0d: id=%h ts=%h le=%h cnt=%0d id_err=%0d ts_err=%0d",
                     cyc, REC_TRIG_ID, REC_TIME_STAMP, REC_LE, REC_CNT, ID_ERR_CNT, TS_ERR_CNT);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_record: got id %h, expected no record", REC_TRIG_ID);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rec_trig_id", REC_TRIG_ID, mon_e.id);
                chk("rec_ts",      REC_TIME_STAMP, mon_e.ts);
                chk("rec_le",      REC_LE, mon_e.le);
                chk("rec_cnt",     REC_CNT, mon_e.cnt);
                chk("id_err_cnt",  ID_ERR_CNT, mon_e.id_err);
                chk("ts_err_cnt",  TS_ERR_CNT, mon_e.ts_err);
            end
        end
        valid_d = REC_VALID;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int hold_bad;

        // Reset state
        repeat (3) tick();
        @(negedge BUS_CLK);
        chk_reset("reset");
        tick();
        RST = 1'b0;
        ENABLE = 1'b1;
        REC_READY = 1'b1;
        tick();

        // Single record, latency read+8
        rd_cyc_q.delete();
        rise_q.delete();
        push_rec(32'd1, 64'h0000_0001_0000_00A5, 32'h44332211, 1, 0, 0, 1'b1);
        wait_exp(0, "t1_done");
        chk("t1_reads", rd_cyc_q.size(), 8);
        if (rd_cyc_q.size() > 0 && rise_q.size() > 0)
            chk("t1_latency", rise_q[0] - rd_cyc_q[0], 8);
        repeat (2) tick();
        pulse_clear();

        // IDs 1,2,4 back to back: one ID gap, 9-cycle period
        rise_q.delete();
        push_rec(32'd1, 64'd10, 32'h01010101, 1, 0, 0, 1'b1);
        push_rec(32'd2, 64'd20, 32'h02020202, 2, 0, 0, 1'b1);
        push_rec(32'd4, 64'd30, 32'h04040404, 3, 1, 0, 1'b1);
        wait_exp(0, "t2_done");
        chk("t2_rises", rise_q.size(), 3);
        if (rise_q.size() == 3) begin
            chk("t2_period_a", rise_q[1] - rise_q[0], 9);
            chk("t2_period_b", rise_q[2] - rise_q[1], 9);
        end

        // Equal timestamps flag a TS error
        push_rec(32'd5, 64'd100, 32'h05050505, 4, 1, 0, 1'b1);
        push_rec(32'd6, 64'd100, 32'h06060606, 5, 1, 1, 1'b1);
        wait_exp(0, "t3_done");
        repeat (2) tick();
        pulse_clear();

        // ID wrap is continuous
        push_rec(32'hFFFF_FFFF, 64'd200, 32'h0A0B0C0D, 1, 0, 0, 1'b1);
        push_rec(32'h0000_0000, 64'd300, 32'h0E0F1011, 2, 0, 0, 1'b1);
        wait_exp(0, "t4_done");
        repeat (2) tick();

        // Back-pressure: held record, no reads, read one cycle after handshake
        REC_READY = 1'b0;
        push_rec(32'd1, 64'd400, 32'hA1B2C3D4, 3, 0, 0, 1'b1);
        push_rec(32'd2, 64'd500, 32'h55667788, 4, 0, 0, 1'b1);
        wait_exp(1, "t5_first");
        hold_bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge BUS_CLK);
            if (FIFO_READ !== 1'b0 || REC_VALID !== 1'b1 || REC_TRIG_ID !== 32'd1 ||
                REC_TIME_STAMP !== 64'd400 || REC_LE !== 32'hA1B2C3D4)
                hold_bad++;
        end
        chk("t5_hold_stable", hold_bad, 0);
        tick();
        REC_READY = 1'b1;
        @(negedge BUS_CLK);
        chk("t5_no_read_in_hs_cycle", FIFO_READ, 0);
        @(negedge BUS_CLK);
        chk("t5_read_after_hs", FIFO_READ, 1);
        chk("t5_valid_low_after_hs", REC_VALID, 0);
        wait_exp(0, "t5_done");
        repeat (2) tick();

        // FIFO gaps every other cycle, ENABLE dropped after word 3 is reached
        base = rd_total;
        push_rec(32'd3, 64'd600, 32'hCAFEBABE, 5, 0, 0, 1'b1);
        for (int i = 0; i < 24; i++) begin
            tick();
            gap = !gap;
            update_fifo();
            if (rd_total - base >= 3)
                ENABLE = 1'b0;
        end
        gap = 1'b0;
        update_fifo();
        wait_exp(0, "t6_done");
        repeat (2) tick();
        base = rd_total;
        push_rec(32'd4, 64'd700, 32'hDEADBEEF, 0, 0, 0, 1'b0);
        repeat (20) tick();
        chk("t6_no_new_reads", rd_total - base, 0);
        chk("t6_no_new_valid", REC_VALID, 0);

        // Reset mid-record at word 4, then a clean record
        base = rd_total;
        ENABLE = 1'b1;
        for (int i = 0; i < 40 && (rd_total - base) < 4; i++)
            tick();
        chk("t7_words_before_rst", rd_total - base, 4);
        RST = 1'b1;
        tick();
        @(negedge BUS_CLK);
        chk_reset("t7_rst");
        tick();
        fifo_q.delete();
        update_fifo();
        RST = 1'b0;
        tick();
        push_rec(32'd9, 64'd50, 32'h13579BDF, 1, 0, 0, 1'b1);
        wait_exp(0, "t7_done");
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
